// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with byte enables, selectable
// read-during-write behaviour, optional output register and a sequential clear engine.
module ram_sp_param #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned DEPTH          = 1 << ADDR_W,
  parameter int unsigned WRITE_MODE     = 2,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic                  write,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  clear,
  output logic                  ready,
  output logic                  busy,
  output logic [DATA_W-1:0]     data_out,
  output logic                  rd_valid
);

  localparam int unsigned NB             = DATA_W / 8;
  localparam int unsigned WM_WRITE_FIRST = 1;
  localparam int unsigned WM_NO_CHANGE   = 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
  logic              start_pend;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc_c, in_range_c, wr_en_c, rd_fire_c;
  logic [DATA_W-1:0] old_c, merged_c, rd_data_c;

  // Access decode: old word, byte-merged word and the value presented on a read strobe
  always_comb begin
    acc_c      = req && ready;
    in_range_c = 32'(address) < DEPTH;
    old_c      = '0;
    if (in_range_c) old_c = mem[address];
    merged_c = old_c;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) merged_c[8*k +: 8] = data_in[8*k +: 8];
    end
    if (!in_range_c) merged_c = '0;
    wr_en_c   = acc_c && write && in_range_c;
    rd_fire_c = acc_c && (!write || (WRITE_MODE != WM_NO_CHANGE));
    rd_data_c = (write && (WRITE_MODE == WM_WRITE_FIRST)) ? merged_c : old_c;
  end

  // Clear engine next-state: one word per cycle, terminal count DEPTH-1
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    case (state)
      IDLE: begin
        if (clear || start_pend) begin
          state_nxt    = CLEAR;
          clr_addr_nxt = '0;
        end
      end
      CLEAR: begin
        if (clr_addr == LAST_ADDR) begin
          state_nxt    = IDLE;
          clr_addr_nxt = '0;
        end else begin
          clr_addr_nxt = clr_addr + ADDR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      clr_addr   <= '0;
      start_pend <= (CLEAR_ON_RESET != 0);
      busy       <= 1'b0;
      ready      <= 1'b1;
    end else begin
      state      <= state_nxt;
      clr_addr   <= clr_addr_nxt;
      start_pend <= 1'b0;
      busy       <= (state_nxt == CLEAR);
      ready      <= (state_nxt != CLEAR);
    end
  end

  // Storage array has no reset; only the clear engine zeroes it
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (wr_en_c) begin
      for (int k = 0; k < NB; k++) begin
        if (be[k]) mem[address][8*k +: 8] <= data_in[8*k +: 8];
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_data;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pipe_valid <= 1'b0;
        pipe_data  <= '0;
        rd_valid   <= 1'b0;
        data_out   <= '0;
      end else begin
        pipe_valid <= rd_fire_c;
        if (rd_fire_c) pipe_data <= rd_data_c;
        rd_valid <= pipe_valid;
        if (pipe_valid) data_out <= pipe_data;
      end
    end
  end else begin : g_out_direct
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_valid <= 1'b0;
        data_out <= '0;
      end else begin
        rd_valid <= rd_fire_c;
        if (rd_fire_c) data_out <= rd_data_c;
      end
    end
  end

endmodule

// File: tb/tb_ram_sp_param.sv
// Directed bench for ram_sp_param: three instances cover defaults (NO_CHANGE),
// 32-bit READ_FIRST with output register, and DEPTH=1000 WRITE_FIRST.
module tb_ram_sp_param;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req, clear;
  logic        write;
  logic [9:0]  address;
  logic [31:0] data_in;
  logic [3:0]  be;

  logic        ready0, busy0, rv0, ready1, busy1, rv1, ready2, busy2, rv2;
  logic [7:0]  dout0, dout2;
  logic [31:0] dout1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_sp_param #(.DATA_W(8), .ADDR_W(10), .DEPTH(1024), .WRITE_MODE(2), .OUT_REG(0),
                 .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .reset_n(reset_n), .req(req[0]), .write(write), .address(address),
    .data_in(data_in[7:0]), .be(be[0:0]), .clear(clear[0]), .ready(ready0), .busy(busy0),
    .data_out(dout0), .rd_valid(rv0));

  ram_sp_param #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .WRITE_MODE(0), .OUT_REG(1),
                 .CLEAR_ON_RESET(0)) u1 (
    .clk(clk), .reset_n(reset_n), .req(req[1]), .write(write), .address(address),
    .data_in(data_in), .be(be), .clear(clear[1]), .ready(ready1), .busy(busy1),
    .data_out(dout1), .rd_valid(rv1));

  ram_sp_param #(.DATA_W(8), .ADDR_W(10), .DEPTH(1000), .WRITE_MODE(1), .OUT_REG(0),
                 .CLEAR_ON_RESET(1)) u2 (
    .clk(clk), .reset_n(reset_n), .req(req[2]), .write(write), .address(address),
    .data_in(data_in[7:0]), .be(be[0:0]), .clear(clear[2]), .ready(ready2), .busy(busy2),
    .data_out(dout2), .rd_valid(rv2));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] r, input logic w, input logic [9:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    req = r; write = w; address = a; data_in = d; be = b;
  endtask

  task automatic test_reset();
    int n0, n2;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL rst_busy0 got=%0b exp=0", busy0); end
    checks++; if (ready0 !== 1'b1) begin failures++; $display("FAIL rst_ready0 got=%0b exp=1", ready0); end
    checks++; if (dout0 !== 8'h00 || rv0 !== 1'b0) begin failures++; $display("FAIL rst_out0 got=%h/%0b exp=00/0", dout0, rv0); end
    checks++; if (dout1 !== 32'h0 || rv1 !== 1'b0) begin failures++; $display("FAIL rst_out1 got=%h/%0b exp=0/0", dout1, rv1); end
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL rst_busy2 got=%0b exp=0", busy2); end
    @(negedge clk) reset_n = 1'b1;
    cyc();
    checks++; if (busy0 !== 1'b1 || ready0 !== 1'b0) begin failures++; $display("FAIL rel_busy0 got=%0b/%0b exp=1/0", busy0, ready0); end
    checks++; if (busy1 !== 1'b0 || ready1 !== 1'b1) begin failures++; $display("FAIL rel_busy1 got=%0b/%0b exp=0/1", busy1, ready1); end
    n0 = 1; n2 = 1;
    for (int i = 0; i < 1100 && (busy0 || busy2); i++) begin
      cyc();
      n0 += int'(busy0);
      n2 += int'(busy2);
    end
    checks++; if (n0 != 1024) begin failures++; $display("FAIL clr_len0 got=%0d exp=1024", n0); end
    checks++; if (n2 != 1000) begin failures++; $display("FAIL clr_len2 got=%0d exp=1000", n2); end
  endtask

  task automatic test_cleared_reads();
    logic [9:0] addrs [3];
    addrs = '{10'h000, 10'h1FF, 10'h3FF};
    foreach (addrs[i]) begin
      drive(3'b001, 1'b0, addrs[i], 32'h0, 4'h0);
      cyc();
      checks++; if (rv0 !== 1'b1 || dout0 !== 8'h00) begin failures++; $display("FAIL clr_rd[%h] got=%h/%0b exp=00/1", addrs[i], dout0, rv0); end
    end
    drive(3'b000, 1'b0, 10'h0, 32'h0, 4'h0);
  endtask

  task automatic test_write_read();
    drive(3'b001, 1'b1, 10'h012, 32'hA5, 4'h1);
    cyc();
    checks++; if (rv0 !== 1'b0) begin failures++; $display("FAIL wr0_rv got=%0b exp=0", rv0); end
    drive(3'b001, 1'b0, 10'h012, 32'h0, 4'h0);
    cyc();
    checks++; if (rv0 !== 1'b1 || dout0 !== 8'hA5) begin failures++; $display("FAIL rd0 got=%h/%0b exp=a5/1", dout0, rv0); end
    drive(3'b000, 1'b0, 10'h0, 32'h0, 4'h0);
    cyc();
    checks++; if (rv0 !== 1'b0 || dout0 !== 8'hA5) begin failures++; $display("FAIL hold0 got=%h/%0b exp=a5/0", dout0, rv0); end
    drive(3'b010, 1'b1, 10'h012, 32'h000000A5, 4'hF);
    cyc();
    drive(3'b000, 1'b0, 10'h0, 32'h0, 4'h0);
    cyc();
    cyc();
    drive(3'b010, 1'b0, 10'h012, 32'h0, 4'h0);
    cyc();
    checks++; if (rv1 !== 1'b0) begin failures++; $display("FAIL outreg_early got=%0b exp=0", rv1); end
    drive(3'b000, 1'b0, 10'h0, 32'h0, 4'h0);
    cyc();
    checks++; if (rv1 !== 1'b1 || dout1 !== 32'hA5) begin failures++; $display("FAIL outreg_rd got=%h/%0b exp=a5/1", dout1, rv1); end
  endtask

  task automatic test_byte_enable();
    drive(3'b010, 1'b1, 10'h020, 32'h11223344, 4'hF);
    cyc();
    drive(3'b010, 1'b1, 10'h020, 32'hAABBCCDD, 4'b0101);
    cyc();
    drive(3'b000, 1'b0, 10'h0, 32'h0, 4'h0);
    cyc();
    checks++; if (rv1 !== 1'b1 || dout1 !== 32'h11223344) begin failures++; $display("FAIL be_oldword got=%h/%0b exp=11223344/1", dout1, rv1); end
    drive(3'b010, 1'b0, 10'h020, 32'h0, 4'h0);
    cyc();
    drive(3'b000, 1'b0, 10'h0, 32'h0, 4'h0);
    cyc();
    checks++; if (rv1 !== 1'b1 || dout1 !== 32'h11BB33DD) begin failures++; $display("FAIL be_merge got=%h/%0b exp=11bb33dd/1", dout1, rv1); end
  endtask

  task automatic test_rdw();
    drive(3'b111, 1'b1, 10'h030, 32'h55, 4'hF);
    cyc();
    checks++; if (rv2 !== 1'b1 || dout2 !== 8'h55) begin failures++; $display("FAIL wf_first got=%h/%0b exp=55/1", dout2, rv2); end
    drive(3'b111, 1'b1, 10'h030, 32'h77, 4'hF);
    cyc();
    checks++; if (rv2 !== 1'b1 || dout2 !== 8'h77) begin failures++; $display("FAIL wf_new got=%h/%0b exp=77/1", dout2, rv2); end
    checks++; if (rv0 !== 1'b0 || dout0 !== 8'hA5) begin failures++; $display("FAIL nc_hold got=%h/%0b exp=a5/0", dout0, rv0); end
    drive(3'b000, 1'b0, 10'h0, 32'h0, 4'h0);
    cyc();
    checks++; if (rv1 !== 1'b1 || dout1 !== 32'h55) begin failures++; $display("FAIL rf_old got=%h/%0b exp=55/1", dout1, rv1); end
    checks++; if (rv2 !== 1'b0) begin failures++; $display("FAIL wf_strobe got=%0b exp=0", rv2); end
    drive(3'b111, 1'b0, 10'h030, 32'h0, 4'h0);
    cyc();
    checks++; if (rv0 !== 1'b1 || dout0 !== 8'h77) begin failures++; $display("FAIL nc_rd got=%h/%0b exp=77/1", dout0, rv0); end
    drive(3'b000, 1'b0, 10'h0, 32'h0, 4'h0);
    cyc();
    checks++; if (rv1 !== 1'b1 || dout1 !== 32'h77) begin failures++; $display("FAIL rf_rd got=%h/%0b exp=77/1", dout1, rv1); end
  endtask

  task automatic test_out_of_range();
    drive(3'b100, 1'b1, 10'd999, 32'h42, 4'h1);
    cyc();
    drive(3'b100, 1'b1, 10'd1010, 32'h99, 4'h1);
    cyc();
    drive(3'b100, 1'b0, 10'd1010, 32'h0, 4'h0);
    cyc();
    checks++; if (rv2 !== 1'b1 || dout2 !== 8'h00) begin failures++; $display("FAIL oor_rd got=%h/%0b exp=00/1", dout2, rv2); end
    drive(3'b100, 1'b0, 10'd999, 32'h0, 4'h0);
    cyc();
    checks++; if (rv2 !== 1'b1 || dout2 !== 8'h42) begin failures++; $display("FAIL last_word got=%h/%0b exp=42/1", dout2, rv2); end
    drive(3'b000, 1'b0, 10'h0, 32'h0, 4'h0);
  endtask

  task automatic test_clear();
    int n;
    bit saw_rv;
    drive(3'b001, 1'b1, 10'h3FF, 32'h3C, 4'h1);
    cyc();
    drive(3'b000, 1'b0, 10'h0, 32'h0, 4'h0);
    clear = 3'b001;
    cyc();
    clear = 3'b000;
    checks++; if (busy0 !== 1'b1 || ready0 !== 1'b0) begin failures++; $display("FAIL clr_start got=%0b/%0b exp=1/0", busy0, ready0); end
    n = 1; saw_rv = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      drive(3'b001, 1'(i % 2), 10'h000, 32'hEE, 4'h1);
      clear = (i == 300) ? 3'b001 : 3'b000;
      cyc();
      if (!busy0) break;
      n++;
      if (rv0) saw_rv = 1'b1;
      if (i == 10) begin
        checks++; if (ready0 !== 1'b0) begin failures++; $display("FAIL clr_ready got=%0b exp=0", ready0); end
      end
    end
    drive(3'b000, 1'b0, 10'h0, 32'h0, 4'h0);
    clear = 3'b000;
    checks++; if (n != 1024) begin failures++; $display("FAIL clr_len got=%0d exp=1024", n); end
    checks++; if (saw_rv !== 1'b0) begin failures++; $display("FAIL clr_rv got=%0b exp=0", saw_rv); end
    drive(3'b001, 1'b0, 10'h000, 32'h0, 4'h0);
    cyc();
    checks++; if (rv0 !== 1'b1 || dout0 !== 8'h00) begin failures++; $display("FAIL clr_drop got=%h/%0b exp=00/1", dout0, rv0); end
    drive(3'b001, 1'b0, 10'h3FF, 32'h0, 4'h0);
    cyc();
    checks++; if (rv0 !== 1'b1 || dout0 !== 8'h00) begin failures++; $display("FAIL clr_wipe got=%h/%0b exp=00/1", dout0, rv0); end
    drive(3'b000, 1'b0, 10'h0, 32'h0, 4'h0);
  endtask

  task automatic test_reset_mid_clear();
    int n0, n2;
    drive(3'b100, 1'b0, 10'h030, 32'h0, 4'h0);
    clear = 3'b100;
    cyc();
    drive(3'b000, 1'b0, 10'h0, 32'h0, 4'h0);
    clear = 3'b000;
    checks++; if (rv2 !== 1'b1 || dout2 !== 8'h77 || busy2 !== 1'b1) begin failures++; $display("FAIL clr_acc got=%h/%0b/%0b exp=77/1/1", dout2, rv2, busy2); end
    repeat (499) cyc();
    checks++; if (busy2 !== 1'b1) begin failures++; $display("FAIL mid_busy got=%0b exp=1", busy2); end
    reset_n = 1'b0;
    #1;
    checks++; if (busy2 !== 1'b0 || ready2 !== 1'b1 || dout2 !== 8'h00) begin failures++; $display("FAIL async_rst got=%0b/%0b/%h exp=0/1/00", busy2, ready2, dout2); end
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    cyc();
    checks++; if (busy1 !== 1'b0 || dout1 !== 32'h0) begin failures++; $display("FAIL rerst1 got=%0b/%h exp=0/0", busy1, dout1); end
    n0 = int'(busy0); n2 = int'(busy2);
    for (int i = 0; i < 1100 && (busy0 || busy2); i++) begin
      cyc();
      n0 += int'(busy0);
      n2 += int'(busy2);
    end
    checks++; if (n2 != 1000) begin failures++; $display("FAIL rerun_len2 got=%0d exp=1000", n2); end
    checks++; if (n0 != 1024) begin failures++; $display("FAIL rerun_len0 got=%0d exp=1024", n0); end
  endtask

  initial begin
    reset_n = 1'b0;
    req = 3'b000; clear = 3'b000; write = 1'b0;
    address = '0; data_in = '0; be = '0;
    test_reset();
    test_cleared_reads();
    test_write_read();
    test_byte_enable();
    test_rdw();
    test_out_of_range();
    test_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
